// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program counter plus IF/ID pipeline register for a
// single-outstanding-request instruction memory. A skid buffer holds a word
// that arrives while the pipeline is stalled. A KILL state swallows the stale
// response to a fetch that a redirect has overtaken.
//
// Handshake: imem_req/imem_addr are held steady while in FETCH until
// imem_ready=1 returns the word for that address. The fetch unit only ever
// has one request in flight, and it never raises imem_req in HELD or KILL.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] npc_in,
    input  logic        redirect,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_out,
    output logic [31:0] pc_add_out,
    output logic [31:0] IF_ID_pc_add_out,
    output logic [31:0] IF_ID_im_out,
    output logic        IF_ID_valid,
    output logic [1:0]  dbg_state_o
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HELD  = 2'd1,
        KILL  = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] skid_q, skid_d;
    logic [31:0] ifid_pc_add_q, ifid_pc_add_d;
    logic [31:0] ifid_im_q, ifid_im_d;
    logic        ifid_valid_q, ifid_valid_d;

    assign pc_out           = pc_q;
    assign pc_add_out       = pc_q + 32'd4;
    assign imem_addr        = pc_q;
    assign IF_ID_pc_add_out = ifid_pc_add_q;
    assign IF_ID_im_out     = ifid_im_q;
    assign IF_ID_valid      = ifid_valid_q;
    assign dbg_state_o      = state_q;

    // Next-state logic: stall beats redirect, and redirect beats sequential advance.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        skid_d        = skid_q;
        ifid_pc_add_d = ifid_pc_add_q;
        ifid_im_d     = ifid_im_q;
        ifid_valid_d  = ifid_valid_q;
        imem_req      = (state_q == FETCH) && !rst;

        if (!stall) begin
            if (redirect) begin
                // Word-align the target. Drop any buffered or arriving word.
                pc_d         = {npc_in[31:2], 2'b00};
                ifid_im_d    = 32'd0;
                ifid_valid_d = 1'b0;
                skid_d       = 32'd0;
                // A request left unanswered must have its response swallowed.
                if (imem_ready || state_q == HELD) begin
                    state_d = FETCH;
                end else begin
                    state_d = KILL;
                end
            end else begin
                case (state_q)
                    FETCH: begin
                        if (imem_ready) begin
                            ifid_pc_add_d = pc_add_out;
                            ifid_im_d     = imem_rdata;
                            ifid_valid_d  = 1'b1;
                            pc_d          = pc_add_out;
                        end else begin
                            ifid_im_d    = 32'd0;
                            ifid_valid_d = 1'b0;
                        end
                    end
                    HELD: begin
                        ifid_pc_add_d = pc_add_out;
                        ifid_im_d     = skid_q;
                        ifid_valid_d  = 1'b1;
                        pc_d          = pc_add_out;
                        state_d       = FETCH;
                    end
                    KILL: begin
                        ifid_im_d    = 32'd0;
                        ifid_valid_d = 1'b0;
                        if (imem_ready) begin
                            state_d = FETCH;
                        end
                    end
                    default: state_d = FETCH;
                endcase
            end
        end else begin
            // Stalled: PC and IF/ID hold. A response is still accepted or dropped.
            case (state_q)
                FETCH: begin
                    if (imem_ready) begin
                        skid_d  = imem_rdata;
                        state_d = HELD;
                    end
                end
                KILL: begin
                    if (imem_ready) begin
                        state_d = FETCH;
                    end
                end
                HELD:    state_d = HELD;
                default: state_d = FETCH;
            endcase
        end
    end

    // State registers with synchronous reset. Reset abandons any request in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= FETCH;
            pc_q          <= {RESET_PC[31:2], 2'b00};
            skid_q        <= 32'd0;
            ifid_pc_add_q <= 32'd0;
            ifid_im_q     <= 32'd0;
            ifid_valid_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            skid_q        <= skid_d;
            ifid_pc_add_q <= ifid_pc_add_d;
            ifid_im_q     <= ifid_im_d;
            ifid_valid_q  <= ifid_valid_d;
        end
    end

endmodule

// File: doc/pc_fetch_unit.md
PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset: `clk` clocks the block and `rst` is the reset.
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_3000: PC value loaded by reset.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 npc_in  in  32  next-PC target from the next-PC selector (jr/jump/branch).
REQ-006 redirect  in  1  npc_in is valid and must replace sequential PC.
REQ-007 stall  in  1  hazard-unit stall: hold PC and IF/ID.
REQ-008 imem_req  out  1  instruction-memory read request.
REQ-009 imem_addr  out  32  instruction address (current PC).
REQ-010 imem_ready  in  1  imem_rdata valid this cycle for the outstanding request.
REQ-011 imem_rdata  in  32  fetched instruction word.
REQ-012 pc_out  out  32  current PC.
REQ-013 pc_add_out  out  32  pc_out + 4, combinational, wraps modulo 2^32.
REQ-014 IF_ID_pc_add_out  out  32  registered PC+4 of the instruction in IF/ID.
REQ-015 IF_ID_im_out  out  32  registered instruction in IF/ID.
REQ-016 IF_ID_valid  out  1  IF/ID holds a real instruction; 0 means bubble.

Function
REQ-017 SHALL implement a 3-state FSM: FETCH (request outstanding), HELD (word captured in skid buffer while stalled), and KILL (discard one stale response after redirect).
REQ-018 FETCH: imem_req=1 and imem_addr=pc_out; on imem_ready=1 with stall=0, load IF/ID with {pc_out+4, imem_rdata}, set IF_ID_valid=1, and set PC to pc_out+4; stay in FETCH.
REQ-019 FETCH, imem_ready=1 and stall=1: capture imem_rdata in the skid buffer, hold PC and IF/ID, go to HELD; imem_req=0 while in HELD.
REQ-020 HELD, stall=0: load IF/ID from the skid buffer, advance PC by 4, return to FETCH; no memory request is issued that cycle.
REQ-021 FETCH, imem_ready=0: hold PC; IF/ID holds its value if stall=1, otherwise IF/ID is loaded with a bubble (IF_ID_valid=0, IF_ID_im_out=0).
REQ-022 SHALL sample redirect only when stall=0; redirect while stall=1 is ignored (hazard unit guarantees it is re-presented).
REQ-023 redirect=1 with stall=0, any state: PC <= {npc_in[31:2], 2'b00}; IF/ID <= bubble; skid buffer discarded; imem_rdata of that cycle ignored.
REQ-024 Redirect next state: FETCH if imem_ready=1 or the current state is HELD (no request outstanding); otherwise KILL.
REQ-025 KILL: imem_req=0; wait for imem_ready=1, drop that word, go to FETCH; further redirects in KILL update PC and stay in KILL.
REQ-026 SHALL apply priority rst > stall > redirect > sequential advance.
REQ-027 SHALL keep PC[1:0] at 2'b00 at all times; PC+4 wraps 32'hFFFF_FFFC to 32'h0000_0000.
REQ-028 Latency: instruction at PC appears on IF_ID_* on the clock edge after the cycle with imem_ready=1 (zero-wait memory gives 1 instruction per cycle).

Reset
REQ-029 On rst=1 at a clock edge: pc_out=RESET_PC; IF_ID_pc_add_out=0; IF_ID_im_out=0; IF_ID_valid=0; skid buffer cleared; FSM=FETCH.
REQ-030 Reset mid-operation SHALL abandon any outstanding request, with no KILL state entered; memory must tolerate the abandoned read.
REQ-031 imem_req SHALL be 0 while rst=1 and 1 in the first cycle after rst is released.

Verification
REQ-032 Reset, then zero-wait memory returning 32'h2408_0001 -> IF_ID_pc_add_out=32'h0000_3004 and IF_ID_valid=1 after edge 1; pc_out=32'h0000_3004.
REQ-033 Word arrives with stall=1 for 3 cycles -> IF/ID unchanged, pc_out unchanged, imem_req=0 in HELD; at the first stall=0 edge, IF/ID takes the buffered word and pc_out advances by 4.
REQ-034 redirect=1, npc_in=32'h0000_3040, imem_ready=0 -> next pc_out=32'h0000_3040, IF_ID_valid=0, FSM=KILL; the next ready word is dropped; the following fetch uses address 32'h0000_3040.
REQ-035 redirect=1 together with stall=1 -> redirect ignored, PC and IF/ID held.
REQ-036 npc_in=32'h0000_3043 -> pc_out=32'h0000_3040; PC=32'hFFFF_FFFC sequential advance -> pc_out=32'h0000_0000.
REQ-037 rst asserted while in HELD -> all outputs at reset values per REQ-029 and the skid word is never delivered.
